// File: rtl/alu_md.sv
// -----------------------------------------------------------------------------
// alu_md : execute-stage ALU with an iterative multiply/divide unit and the
//          architectural HI/LO registers.
//
// Single-cycle ops (add/sub/logic/compare/LUI/shifts/MFHI/MFLO) drive o_y
// combinationally. MULT/MULTU/DIV/DIVU run as an IDLE -> RUN -> DONE sequence,
// with one radix-2 step per RUN cycle. HI/LO are committed at the end of the
// DONE cycle.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   i_a, i_b     operands (a = rs / shamt source, b = rt / immediate)
//   i_op         8-bit operation code
//   i_start      EX holds a real instruction this cycle
//   i_cancel     flush; aborts any multiply/divide in flight
//   o_y          combinational result
//   o_overflow   signed overflow (ADD/SUB only)
//   o_zero       o_y == 0
//   o_hi, o_lo   current HI/LO contents
//   o_stall      stall request to hazard control
//   o_done       one-cycle pulse; HI/LO are written at the end of this cycle
// -----------------------------------------------------------------------------
module alu_md #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [7:0]       i_op,
  input  logic             i_start,
  input  logic             i_cancel,
  output logic [WIDTH-1:0] o_y,
  output logic             o_overflow,
  output logic             o_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_stall,
  output logic             o_done
);

  // Operation codes (EXE_*_OP encodings of the core)
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_LUI   = 8'b0101_1100;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc;      // product high half / partial remainder
  logic [WIDTH-1:0] r_q;        // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] r_m;        // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_a_raw;    // original dividend, returned as HI on /0
  logic             r_is_div;
  logic             r_neg;      // product or quotient must be negated
  logic             r_rem_neg;  // remainder takes the dividend's sign
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_lui;
  logic [SHW-1:0]   w_sh;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_sh   = i_a[SHW-1:0];

  // LUI only makes sense when a 16-bit immediate fits in the upper half.
  generate
    if (WIDTH >= 32) begin : g_lui
      assign w_lui = {i_b[15:0], {(WIDTH-16){1'b0}}};
    end else begin : g_no_lui
      assign w_lui = '0;
    end
  endgenerate

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD, OP_ADDU: o_y = w_sum;
      OP_SUB, OP_SUBU: o_y = w_diff;
      OP_AND:          o_y = i_a & i_b;
      OP_OR:           o_y = i_a | i_b;
      OP_XOR:          o_y = i_a ^ i_b;
      OP_NOR:          o_y = ~(i_a | i_b);
      OP_SLT:          o_y = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU:         o_y = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      OP_LUI:          o_y = w_lui;
      OP_SLL:          o_y = i_b << w_sh;
      OP_SRL:          o_y = i_b >> w_sh;
      OP_SRA:          o_y = $unsigned($signed(i_b) >>> w_sh);
      OP_MFHI:         o_y = r_hi;
      OP_MFLO:         o_y = r_lo;
      default:         o_y = '0;
    endcase
  end

  always_comb begin
    o_overflow = 1'b0;
    case (i_op)
      OP_ADD: o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1]  != i_a[WIDTH-1]);
      OP_SUB: o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      default: o_overflow = 1'b0;
    endcase
  end

  assign o_zero = (o_y == '0);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

  // ---------------------------------------------------------------------------
  // Multiply/divide decode and operand conditioning
  // ---------------------------------------------------------------------------
  logic             w_is_md;
  logic             w_op_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_accept;
  logic             w_commit;

  assign w_is_md     = i_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign w_op_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_a_neg     = w_op_signed & i_a[WIDTH-1];
  assign w_b_neg     = w_op_signed & i_b[WIDTH-1];
  // The most-negative value maps onto itself, which is its correct unsigned
  // magnitude, so MIN / -1 naturally yields lo = MIN, hi = 0.
  assign w_a_mag     = w_a_neg ? ('0 - i_a) : i_a;
  assign w_b_mag     = w_b_neg ? ('0 - i_b) : i_b;
  assign w_accept    = (r_state == S_IDLE) && i_start && w_is_md && !i_cancel;
  assign w_commit    = (r_state == S_DONE) && !i_cancel;

  // One radix-2 step: shift-add multiply (LSB first) or restoring divide.
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_q_bit;

  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
  assign w_rem_sh  = {r_acc, r_q[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_m};
  assign w_q_bit   = !w_trial[WIDTH];

  // Final sign correction of the magnitude result.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod = r_neg     ? ('0 - {r_acc, r_q}) : {r_acc, r_q};
  assign w_quo  = r_neg     ? ('0 - r_q)          : r_q;
  assign w_rem  = r_rem_neg ? ('0 - r_acc)        : r_acc;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_stall      = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_RUN;
          o_stall      = 1'b1;
        end
      end
      S_RUN: begin
        o_stall = 1'b1;
        if (i_cancel)
          w_state_next = S_IDLE;
        else if (r_cnt == SHW'(WIDTH-1))
          w_state_next = S_DONE;
      end
      S_DONE: begin
        // Stall already released so the MD instruction leaves EX now.
        o_done       = !i_cancel;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath and HI/LO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_a_raw   <= '0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_accept) begin
        r_cnt     <= '0;
        r_acc     <= '0;
        r_q       <= w_a_mag;
        r_m       <= w_b_mag;
        r_a_raw   <= i_a;
        r_is_div  <= (i_op == OP_DIV) || (i_op == OP_DIVU);
        r_neg     <= w_a_neg ^ w_b_neg;
        r_rem_neg <= w_a_neg;
        r_div0    <= (i_b == '0);
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + SHW'(1);
        if (r_is_div) begin
          r_acc <= w_q_bit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_q_bit};
        end else begin
          r_acc <= w_mul_sum[WIDTH:1];
          r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
      end

      if (w_commit) begin
        if (r_is_div) begin
          if (r_div0) begin
            r_lo <= '1;
            r_hi <= r_a_raw;
          end else begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end else if ((r_state == S_IDLE) && i_start && !i_cancel) begin
        if (i_op == OP_MTHI) r_hi <= i_a;
        if (i_op == OP_MTLO) r_lo <= i_a;
      end
    end
  end

endmodule

// File: tb/tb_alu_md.sv
module tb_alu_md;

  localparam int W = 32;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_LUI   = 8'b0101_1100;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [7:0]   op;
  logic         start;
  logic         cancel;
  logic [W-1:0] y;
  logic         ovf;
  logic         zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         stall;
  logic         done;

  int n_total = 0;
  int n_bad   = 0;

  alu_md #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_a        (a),
    .i_b        (b),
    .i_op       (op),
    .i_start    (start),
    .i_cancel   (cancel),
    .o_y        (y),
    .o_overflow (ovf),
    .o_zero     (zero),
    .o_hi       (hi),
    .o_lo       (lo),
    .o_stall    (stall),
    .o_done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         ovf;
  } comb_vec_t;

  localparam int NCOMB = 18;
  comb_vec_t comb_tab [NCOMB] = '{
    '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1},
    '{OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0},
    '{OP_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1},
    '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0},
    '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
    '{OP_SUBU, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0},
    '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0},
    '{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0},
    '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0},
    '{OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0},
    '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
    '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
    '{OP_LUI,  32'h0000_0000, 32'hABCD_1234, 32'h1234_0000, 1'b0},
    '{OP_SLL,  32'h0000_0004, 32'h0000_0001, 32'h0000_0010, 1'b0},
    '{OP_SRL,  32'h0000_001F, 32'h8000_0000, 32'h0000_0001, 1'b0},
    '{OP_SRA,  32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0},
    '{OP_SRL,  32'h0000_0024, 32'h8000_0000, 32'h0800_0000, 1'b0},
    '{OP_MULT, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 1'b0}
  };

  // Issue one iterative op and follow it to completion.
  task automatic run_md(input string tag, input logic [7:0] t_op,
                        input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int nstall = 0;
    int cyc    = 0;
    bit got_done = 0;
    @(posedge clk); #1;
    op = t_op; a = t_a; b = t_b; start = 1'b1;
    while (!got_done && cyc < 100) begin
      #1;
      if (done) begin
        got_done = 1;
        check({tag, " stall_in_done"}, stall, 0);
      end else begin
        if (stall) nstall++;
        @(posedge clk); #1;
        start = 1'b0;
        op    = OP_NOP;
        cyc++;
      end
    end
    check({tag, " done_seen"}, got_done, 1);
    check({tag, " stall_cycles"}, nstall, W + 1);
    @(posedge clk); #1;
    op = OP_MFHI; #1;
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " mfhi"}, y, exp_hi);
    op = OP_MFLO; #1;
    check({tag, " mflo"}, y, exp_lo);
    op = OP_NOP;
    $display("txn %s a=%08h b=%08h hi=%08h lo=%08h stalls=%0d", tag, t_a, t_b, hi, lo, nstall);
  endtask

  initial begin
    int ndone;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = OP_NOP; a = '0; b = '0;

    // Reset
    #2 rst = 1'b1;
    #1;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset stall", stall, 0);
    check("reset done", done, 0);
    @(posedge clk); #2 rst = 1'b0;
    $display("txn reset");

    // Single-cycle ops
    for (int i = 0; i < NCOMB; i++) begin
      op = comb_tab[i].op; a = comb_tab[i].a; b = comb_tab[i].b;
      #1;
      check($sformatf("comb%0d y", i), y, comb_tab[i].y);
      check($sformatf("comb%0d ovf", i), ovf, comb_tab[i].ovf);
      check($sformatf("comb%0d zero", i), zero, (comb_tab[i].y == '0));
      check($sformatf("comb%0d stall", i), stall, 0);
      $display("txn comb op=%02h a=%08h b=%08h y=%08h ovf=%0b", op, a, b, y, ovf);
    end
    op = OP_NOP;

    // Iterative ops
    run_md("MULT -3*5",     OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("MULTU max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("DIVU 100/7",    OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14);
    run_md("DIV -7/2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("DIV min/-1",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_md("DIVU 9/0",      OP_DIVU,  32'd9,         32'd0,        32'd9,         32'hFFFF_FFFF);

    // MTHI / MTLO
    @(posedge clk); #1;
    op = OP_MTHI; a = 32'h1234; start = 1'b1;
    #1 check("mthi before edge", hi, 32'hFFFF_FFFF & 32'd9);
    @(posedge clk); #1;
    start = 1'b0; op = OP_MFHI; #1;
    check("mthi hi", hi, 32'h1234);
    check("mthi mfhi", y, 32'h1234);
    op = OP_MTLO; a = 32'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
    check("mtlo lo", lo, 32'h5678);
    $display("txn mthi/mtlo hi=%08h lo=%08h", hi, lo);

    // MULT 2x3 cancelled on RUN cycle 10
    op = OP_MULT; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;              // RUN cycle 1
    start = 1'b0; op = OP_NOP;
    repeat (9) @(posedge clk);       // RUN cycle 10
    #1;
    check("cancel run stall", stall, 1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    #1 check("cancel stall_after", stall, 0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("cancel done_pulses", ndone, 0);
    check("cancel hi", hi, 32'h1234);
    check("cancel lo", lo, 32'h5678);
    $display("txn cancel hi=%08h lo=%08h", hi, lo);

    // start and cancel together in IDLE
    @(posedge clk); #1;
    op = OP_MULT; a = 32'd2; b = 32'd3; start = 1'b1; cancel = 1'b1;
    #1 check("startcancel stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; op = OP_NOP;
    #1 check("startcancel not_run", stall, 0);
    $display("txn start+cancel stall=%0b", stall);

    // Asynchronous reset in the middle of RUN
    @(posedge clk); #1;
    op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
    repeat (5) @(posedge clk);
    #3;
    check("async pre stall", stall, 1);
    rst = 1'b1;
    #1;
    check("async stall", stall, 0);
    check("async hi", hi, 0);
    check("async lo", lo, 0);
    check("async done", done, 0);
    #1 rst = 1'b0;
    $display("txn async reset hi=%08h lo=%08h", hi, lo);

    run_md("MULTU 6*7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage ALU with an integrated multi-cycle multiply/divide unit and architectural HI/LO registers. It keeps the single-cycle arithmetic, logic, compare and LUI operations and adds shifts, MFHI/MFLO/MTHI/MTLO, and iterative MULT/MULTU/DIV/DIVU. It sits in the EX stage of the pipelined MIPS core and raises a stall request to hazard control while an iterative operation runs.

## Interface
- WIDTH, 32, datapath width; even, ≥8, power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a, b  in  WIDTH  operands; a = rs / shamt source, b = rt / immediate.
- op  in  8  operation code; `EXE_*_OP` values from defines.vh.
- start  in  1  op is valid this cycle; EX holds a real instruction.
- cancel  in  1  flush from exception/branch logic; aborts any MD operation.
- y  out  WIDTH  combinational result.
- overflow  out  1  signed overflow; ADD/SUB only.
- zero  out  1  y == 0.
- hi, lo  out  WIDTH  current HI/LO register contents.
- stall  out  1  hazard-control stall request.
- done  out  1  one-cycle pulse; MD result is written at the end of this cycle.

## Operation
- Combinational ops are independent of start:
  - ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/LUI behave as in the existing core, generalised to WIDTH. LUI = {b[15:0], zeros}, and it requires WIDTH≥32.
  - SLL/SRL/SRA shift b by a[SHW-1:0].
  - MFHI → y=hi; MFLO → y=lo.
  - Any other op, including MD ops → y=0.
- Overflow:
  - ADD: operands have equal signs and the sum sign differs.
  - SUB: operand signs differ and the result sign differs from a.
  - Every other op → 0.
- MTHI/MTLO: with start=1 in IDLE, hi←a or lo←a at the edge. No stall. Ignored outside IDLE.
- Iterative ops MULT/MULTU/DIV/DIVU, FSM IDLE → RUN → DONE:
  - IDLE → RUN: start & iterative op & !cancel. Latch operand magnitudes and sign flags, clear the counter.
  - RUN: one radix-2 step per cycle (shift-add multiply, restoring divide). The counter runs 0..WIDTH-1. When counter==WIDTH-1, go to DONE.
  - DONE: done=1. At the closing edge, commit hi/lo and return to IDLE. start is ignored in DONE.
  - cancel in RUN or DONE → IDLE at the next edge; hi/lo unchanged; done forced to 0.
- Results:
  - MULT/MULTU: {hi,lo} = 2·WIDTH-bit product, signed or unsigned respectively.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Most-negative ÷ −1 → lo = most-negative, hi = 0.
  - Divide by zero (b==0) → lo = all ones, hi = a. All WIDTH cycles are still spent.
- stall = (IDLE & start & iterative op & !cancel) | RUN. stall is 0 in DONE, so the MD instruction leaves EX that cycle.
- Reset: state IDLE, counter 0, hi=lo=0, stall=0, done=0.

## Timing
- Combinational ops, MFHI/MFLO: zero latency.
- MTHI/MTLO: the write is visible the cycle after acceptance.
- Iterative op accepted in cycle c0:
  - stall=1 in c0..cWIDTH, i.e. WIDTH+1 cycles.
  - done=1 in c(WIDTH+1).
  - New hi/lo are visible from c(WIDTH+2). MFHI issued right behind the MD op reads the new value with no bypass.
- rst asserted mid-RUN: immediate return to reset values with no clock needed. The MD result is lost.
- cancel and start in the same IDLE cycle: the op is not accepted and stall=0.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → y=0x80000000, overflow=1, zero=0. ADDU with the same operands → overflow=0. SUB a=5, b=5 → zero=1.
- MULT a=−3, b=5 (WIDTH=32) → stall for 33 cycles, done in the 34th, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 → lo=14, hi=2. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIVU 9/0 → same cycle count as a normal divide, lo=0xFFFFFFFF, hi=9.
- MTHI 0x1234, then MULT 2×3, asserting cancel on RUN cycle 10 → stall drops the next cycle, no done pulse, hi stays 0x1234.
- Async rst pulse mid-RUN between clock edges → stall=0, hi=lo=0 immediately. The next MULTU 6×7 gives lo=42.
